// File: rtl/pc_pkg.sv
// Shared constants for the pointer counter: direction and terminal-mode encodings
// plus the AES pointer limits.
package pc_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    localparam int unsigned BYTE_PTR_LIMIT  = 15;
    localparam int unsigned ROUND_LIMIT_128 = 10;
    localparam int unsigned ROUND_LIMIT_192 = 12;
    localparam int unsigned ROUND_LIMIT_256 = 14;

endpackage

// File: rtl/pointer_counter_param_if.sv
// Control/status bundle of the pointer counter; master drives controls, slave is the counter.
// wrap_cnt is present only when PC_WRAP_COUNT_EN is defined.
interface pointer_counter_param_if #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned WCNT_WIDTH = 4
) ();

    logic             clear_pc;
    logic             enable;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             use_def_limit;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] pc;
    logic             overflow_flag;
    logic             wrap_pulse;

`ifdef PC_WRAP_COUNT_EN
    logic [WCNT_WIDTH-1:0] wrap_cnt;

    modport master (
        output clear_pc, enable, dir, load, load_val, use_def_limit, limit,
        input  pc, overflow_flag, wrap_pulse, wrap_cnt
    );

    modport slave (
        input  clear_pc, enable, dir, load, load_val, use_def_limit, limit,
        output pc, overflow_flag, wrap_pulse, wrap_cnt
    );
`else
    localparam int unsigned unused_wcnt_width = WCNT_WIDTH;

    modport master (
        output clear_pc, enable, dir, load, load_val, use_def_limit, limit,
        input  pc, overflow_flag, wrap_pulse
    );

    modport slave (
        input  clear_pc, enable, dir, load, load_val, use_def_limit, limit,
        output pc, overflow_flag, wrap_pulse
    );
`endif

endinterface

// File: rtl/pc_wrap_tracker.sv
// Registers the one-cycle wrap pulse; with PC_WRAP_COUNT_EN also counts wrap steps
// modulo 2^WCNT_WIDTH (cleared by rst and clear).
module pc_wrap_tracker #(
    parameter int unsigned WCNT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PC_WRAP_COUNT_EN
    input  logic                  clear,
    output logic [WCNT_WIDTH-1:0] wrap_cnt,
`endif
    input  logic                  wrap_step,
    output logic                  wrap_pulse
);

    logic wrap_pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_pulse_q <= 1'b0;
        end else begin
            wrap_pulse_q <= wrap_step;
        end
    end

    assign wrap_pulse = wrap_pulse_q;

`ifdef PC_WRAP_COUNT_EN
    localparam logic [WCNT_WIDTH-1:0] CntOne = WCNT_WIDTH'(1);

    logic [WCNT_WIDTH-1:0] wrap_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wrap_cnt_q <= '0;
        end else if (wrap_step) begin
            wrap_cnt_q <= wrap_cnt_q + CntOne;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`else
    localparam int unsigned unused_wcnt_width = WCNT_WIDTH;
`endif

endmodule

// File: rtl/pointer_counter_param.sv
// Up/down pointer counter between 0 and a programmable limit with wrap or saturate.
// Optional wrap counter output enabled by PC_WRAP_COUNT_EN.
module pointer_counter_param
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEF_LIMIT  = BYTE_PTR_LIMIT,
    parameter int unsigned SATURATE   = MODE_WRAP,
    parameter int unsigned WCNT_WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    pointer_counter_param_if.slave bus
);

    localparam logic [WIDTH-1:0] DefLimit = WIDTH'(DEF_LIMIT);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] eff_limit, start_val, load_clamped;
    logic             terminal;
    logic             wrap_step;

    assign eff_limit    = bus.use_def_limit ? DefLimit : bus.limit;
    assign start_val    = (bus.dir == DIR_DOWN) ? eff_limit : '0;
    // Up direction treats anything at or above the limit as terminal (limit lowered mid-count).
    assign terminal     = (bus.dir == DIR_UP) ? (pc_q >= eff_limit) : (pc_q == '0);
    assign load_clamped = (bus.load_val > eff_limit) ? eff_limit : bus.load_val;

    always_comb begin
        pc_d      = pc_q;
        wrap_step = 1'b0;
        if (bus.clear_pc) begin
            pc_d = start_val;
        end else if (bus.load) begin
            pc_d = load_clamped;
        end else if (bus.enable) begin
            if (!terminal) begin
                pc_d = (bus.dir == DIR_DOWN) ? (pc_q - One) : (pc_q + One);
            end else if (SATURATE == MODE_WRAP) begin
                pc_d      = start_val;
                wrap_step = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.overflow_flag = terminal;

    pc_wrap_tracker #(
        .WCNT_WIDTH(WCNT_WIDTH)
    ) u_wrap_tracker (
        .clk       (clk),
        .rst       (rst),
`ifdef PC_WRAP_COUNT_EN
        .clear     (bus.clear_pc),
        .wrap_cnt  (bus.wrap_cnt),
`endif
        .wrap_step (wrap_step),
        .wrap_pulse(bus.wrap_pulse)
    );

endmodule

// File: tb/tb_pointer_counter_param.sv
// Bench for pointer_counter_param: wrapping DUT driven from a vector table plus
// hand sequences, and a saturating DUT. Checks wrap_cnt when PC_WRAP_COUNT_EN is defined.
module tb_pointer_counter_param;
    import pc_pkg::*;

    localparam int unsigned W = 4;

    typedef struct {
        logic       r;
        logic       clr;
        logic       en;
        logic       dir;
        logic       ld;
        logic [3:0] ld_val;
        logic       use_def;
        logic [3:0] lim;
        logic [3:0] e_pc;
        logic       e_of;
        logic       e_wp;
    } vec_t;

    typedef struct {
        logic [3:0] pc;
        logic       of;
        logic       wp;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    always #5 clk = ~clk;

    pointer_counter_param_if #(.WIDTH(W), .WCNT_WIDTH(4)) bus ();
    pointer_counter_param_if #(.WIDTH(W), .WCNT_WIDTH(4)) bus_s ();

    pointer_counter_param #(
        .WIDTH(W), .DEF_LIMIT(15), .SATURATE(MODE_WRAP), .WCNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    pointer_counter_param #(
        .WIDTH(W), .DEF_LIMIT(15), .SATURATE(MODE_SAT), .WCNT_WIDTH(4)
    ) dut_sat (
        .clk(clk),
        .rst(rst_s),
        .bus(bus_s)
    );

    exp_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic clr, input logic en, input logic d,
                                input logic ld, input logic [3:0] lv, input logic ud,
                                input logic [3:0] lim, input logic [3:0] p, input logic o,
                                input logic w);
        vec_t v;
        v.r = r; v.clr = clr; v.en = en; v.dir = d; v.ld = ld; v.ld_val = lv;
        v.use_def = ud; v.lim = lim; v.e_pc = p; v.e_of = o; v.e_wp = w;
        return v;
    endfunction

    task automatic pop_check(input logic [3:0] pc, input logic of, input logic wp);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".pc"}, 32'(pc), 32'(e.pc));
            check({e.tag, ".overflow_flag"}, 32'(of), 32'(e.of));
            check({e.tag, ".wrap_pulse"}, 32'(wp), 32'(e.wp));
        end
    endtask

    task automatic drive(input vec_t v, input string tag);
        @(negedge clk);
        rst                = v.r;
        bus.clear_pc       = v.clr;
        bus.enable         = v.en;
        bus.dir            = v.dir;
        bus.load           = v.ld;
        bus.load_val       = v.ld_val;
        bus.use_def_limit  = v.use_def;
        bus.limit          = v.lim;
        sb.push_back('{pc: v.e_pc, of: v.e_of, wp: v.e_wp, tag: tag});
        @(posedge clk);
        #1;
        pop_check(bus.pc, bus.overflow_flag, bus.wrap_pulse);
    endtask

    task automatic drive_s(input vec_t v, input string tag);
        @(negedge clk);
        rst_s                = v.r;
        bus_s.clear_pc       = v.clr;
        bus_s.enable         = v.en;
        bus_s.dir            = v.dir;
        bus_s.load           = v.ld;
        bus_s.load_val       = v.ld_val;
        bus_s.use_def_limit  = v.use_def;
        bus_s.limit          = v.lim;
        sb.push_back('{pc: v.e_pc, of: v.e_of, wp: v.e_wp, tag: tag});
        @(posedge clk);
        #1;
        pop_check(bus_s.pc, bus_s.overflow_flag, bus_s.wrap_pulse);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        bus.clear_pc = 1'b0; bus.enable = 1'b0; bus.dir = DIR_UP; bus.load = 1'b0;
        bus.load_val = '0; bus.use_def_limit = 1'b1; bus.limit = '0;
        bus_s.clear_pc = 1'b0; bus_s.enable = 1'b0; bus_s.dir = DIR_UP; bus_s.load = 1'b0;
        bus_s.load_val = '0; bus_s.use_def_limit = 1'b0; bus_s.limit = 4'd3;

        // Reset, then up-count with default limit 15 for 17 enables
        tbl.push_back(mk(1, 0, 0, DIR_UP, 0, 0, 1, 0, 4'd0, 0, 0));
        for (int k = 1; k <= 15; k++)
            tbl.push_back(mk(0, 0, 1, DIR_UP, 0, 0, 1, 0, 4'(k), k == 15, 0));
        tbl.push_back(mk(0, 0, 1, DIR_UP, 0, 0, 1, 0, 4'd0, 0, 1));
        tbl.push_back(mk(0, 0, 1, DIR_UP, 0, 0, 1, 0, 4'd1, 0, 0));
        // Down-count with runtime limit 9
        tbl.push_back(mk(0, 1, 0, DIR_DOWN, 0, 0, 0, 9, 4'd9, 0, 0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(0, 0, 1, DIR_DOWN, 0, 0, 0, 9, 4'(9 - k), k == 9, 0));
        tbl.push_back(mk(0, 0, 1, DIR_DOWN, 0, 0, 0, 9, 4'd9, 0, 1));

        for (int i = 0; i < tbl.size(); i++) drive(tbl[i], $sformatf("vec%0d", i));
`ifdef PC_WRAP_COUNT_EN
        check("wrap_cnt_after_down", 32'(bus.wrap_cnt), 32'd1);
`endif

        // Priority: clear beats load and enable; load clamps to limit
        drive(mk(0, 0, 0, DIR_UP, 1, 4'd5, 1, 0, 4'd5, 0, 0), "load5");
        drive(mk(0, 1, 1, DIR_UP, 1, 4'd12, 1, 0, 4'd0, 0, 0), "clr_ld_en");
`ifdef PC_WRAP_COUNT_EN
        check("wrap_cnt_cleared", 32'(bus.wrap_cnt), 32'd0);
`endif
        drive(mk(0, 0, 0, DIR_UP, 1, 4'd12, 0, 4'd10, 4'd10, 1, 0), "load_clamp");

        // Limit lowered below pc: terminal immediately, wraps on enable
        drive(mk(0, 0, 0, DIR_UP, 1, 4'd12, 1, 0, 4'd12, 0, 0), "load12");
        @(negedge clk);
        bus.load = 1'b0; bus.use_def_limit = 1'b0; bus.limit = 4'd7;
        #1;
        check("of_pc_above_limit", 32'(bus.overflow_flag), 32'd1);
        drive(mk(0, 0, 1, DIR_UP, 0, 0, 0, 4'd7, 4'd0, 0, 1), "wrap_low_limit");
        drive(mk(0, 0, 0, DIR_UP, 0, 0, 0, 4'd7, 4'd0, 0, 0), "pulse_drop");
`ifdef PC_WRAP_COUNT_EN
        check("wrap_cnt_low_limit", 32'(bus.wrap_cnt), 32'd1);
`endif
        drive(mk(0, 0, 0, DIR_UP, 1, 4'd12, 1, 0, 4'd12, 0, 0), "reload12");
        drive(mk(0, 0, 1, DIR_DOWN, 0, 0, 0, 4'd7, 4'd11, 0, 0), "down_above_limit");

        // Terminal pc without enable holds; dir change applies on the same edge
        drive(mk(0, 0, 0, DIR_UP, 1, 4'd15, 1, 0, 4'd15, 1, 0), "load15");
        for (int k = 0; k < 3; k++)
            drive(mk(0, 0, 0, DIR_UP, 0, 0, 1, 0, 4'd15, 1, 0), $sformatf("hold15_%0d", k));
        drive(mk(0, 0, 1, DIR_DOWN, 0, 0, 1, 0, 4'd14, 0, 0), "dir_flip");

        // Zero limit: always terminal, every enabled step wraps
        drive(mk(0, 0, 0, DIR_UP, 1, 4'd9, 0, 4'd0, 4'd0, 1, 0), "load_l0");
        drive(mk(0, 0, 1, DIR_UP, 0, 0, 0, 4'd0, 4'd0, 1, 1), "l0_wrap_a");
        drive(mk(0, 0, 1, DIR_UP, 0, 0, 0, 4'd0, 4'd0, 1, 1), "l0_wrap_b");
`ifdef PC_WRAP_COUNT_EN
        check("wrap_cnt_before_rst", 32'(bus.wrap_cnt), 32'd3);
`endif
        // rst overrides a pending wrap step
        drive(mk(1, 0, 1, DIR_UP, 0, 0, 0, 4'd0, 4'd0, 1, 0), "rst_over_wrap");
`ifdef PC_WRAP_COUNT_EN
        check("wrap_cnt_after_rst", 32'(bus.wrap_cnt), 32'd0);
`endif
        drive(mk(0, 0, 1, DIR_UP, 0, 0, 1, 0, 4'd1, 0, 0), "count_after_rst");

        // Saturating instance: up to limit 3 then hold, never pulse
        drive_s(mk(1, 0, 0, DIR_UP, 0, 0, 0, 4'd3, 4'd0, 0, 0), "sat_rst");
        for (int k = 1; k <= 6; k++) begin
            logic [3:0] p;
            p = (k >= 3) ? 4'd3 : 4'(k);
            drive_s(mk(0, 0, 1, DIR_UP, 0, 0, 0, 4'd3, p, p == 4'd3, 0),
                    $sformatf("sat_up%0d", k));
        end
        drive_s(mk(0, 0, 0, DIR_DOWN, 1, 4'd0, 0, 4'd3, 4'd0, 1, 0), "sat_load0");
        drive_s(mk(0, 0, 1, DIR_DOWN, 0, 0, 0, 4'd3, 4'd0, 1, 0), "sat_down_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
